kernel_layer_sequencer: RTL and testbench
=========================================

Name: kernel_layer_sequencer

Overview:
- Sequences the kernel datapath through its convolution layers: mode 00, then 01, then 10.
- Drives the kernel mode and kernel-control reset.
- Counts kernel passes by watching the input flag from kernel control.
- Reports per-layer and whole-run completion to the top-level controller.
- Sits between the host start/abort interface and kernel control. It replaces the static kernel_mode tie-off with a scheduled mode.

Parameters:
- PASS_L0, 4, kernel passes run in layer 0 (mode 00, 9-cycle period).
- PASS_L1, 16, kernel passes run in layer 1 (mode 01, 33-cycle period).
- PASS_L2, 64, kernel passes run in layer 2 (mode 10, 128-cycle period).
- CNT_W, 7, width of the pass counter; must hold max(PASS_Lx)+1.

Ports:
- CLK  in  1  system clock; all registers update on the falling edge.
- RESET_N  in  1  synchronous, active-low reset.
- START  in  1  one-cycle request to begin a run; sampled only in IDLE.
- ABORT  in  1  abandon the run; honoured in every state.
- FIRST_LAYER  in  2  first layer to run (0..2); sampled with START.
- LAST_LAYER  in  2  last layer to run (0..2); sampled with START.
- IN_FLAG  in  1  input_flag_kernel from kernel control; one-cycle pulse at each period start.
- KERNEL_MODE  out  2  mode to kernel control; 2'b11 = park.
- KERN_RST  out  1  active-high reset pulse to kernel control, asserted at each layer start.
- LAYER  out  2  index of the current layer.
- PASS_CNT  out  CNT_W  passes completed in the current layer.
- BUSY  out  1  high in every state except IDLE.
- LAYER_DONE  out  1  one-cycle pulse when a layer completes.
- DONE  out  1  one-cycle pulse when the run completes.
- CFG_ERR  out  1  one-cycle pulse when START is rejected.

Behaviour:
- Reset (RESET_N=0 at a falling edge):
  - State IDLE, KERNEL_MODE=2'b11, KERN_RST=0, LAYER=0, PASS_CNT=0.
  - BUSY, LAYER_DONE, DONE and CFG_ERR all 0.
  - Reset overrides all other inputs, including when it arrives mid-run.
- IDLE:
  - KERNEL_MODE held at 11, which parks kernel control's counter.
  - On START=1 with FIRST<=LAST and both <=2: latch FIRST/LAST, set LAYER=FIRST, go to ARM.
  - On START=1 with bad config: pulse CFG_ERR for one cycle and stay in IDLE.
- ARM (exactly 1 cycle):
  - KERNEL_MODE=LAYER, KERN_RST=1, PASS_CNT cleared to 0; go to RUN.
- RUN:
  - KERN_RST=0, KERNEL_MODE=LAYER.
  - The first IN_FLAG pulse marks the start of pass 1 and is not counted.
  - Each later IN_FLAG pulse increments PASS_CNT.
  - When PASS_CNT reaches PASS_L[LAYER], go to NEXT. The pulse that completes the last pass does not start a new pass.
- NEXT (1 cycle):
  - Pulse LAYER_DONE; KERNEL_MODE=11.
  - If LAYER==LAST_LAYER, go to FIN.
  - Otherwise increment LAYER and go to ARM.
- FIN (1 cycle): pulse DONE, KERNEL_MODE=11, LAYER and PASS_CNT hold; go to IDLE.
- ABORT=1 in any state:
  - Next state is IDLE with KERNEL_MODE=11 and PASS_CNT=0.
  - No LAYER_DONE or DONE pulse is issued.
  - ABORT outranks START and RUN completion in the same cycle.
- START while BUSY is ignored: no error, no effect.
- IN_FLAG outside RUN is ignored.
- PASS_CNT saturates at PASS_L[LAYER] and never wraps.
- Latency: DONE arrives 1 cycle after the final LAYER_DONE.

Decomposition:
- Shared package kernel_pkg holds:
  - Mode constants: MODE_K0=2'b00, MODE_K1=2'b01, MODE_K2=2'b10, MODE_PARK=2'b11.
  - The state encoding: IDLE, ARM, RUN, NEXT, FIN.
  - Period constants 9, 33 and 128, shared with kernel control.
- One natural sub-module, kernel_pass_counter:
  - Counts IN_FLAG pulses with a first-pulse skip, clear, saturate and a terminal-count flag.
  - The FSM stays in the top module.

Test Plan (bench instantiates kernel_control and uses PASS_L0=2, PASS_L1=2, PASS_L2=1):
- Reset, then idle: KERNEL_MODE=11, BUSY=0, and no flags pulse for 50 cycles.
- START with FIRST=0, LAST=0:
  - KERN_RST pulses once, KERNEL_MODE=00, and PASS_CNT steps 1, 2.
  - LAYER_DONE pulses 18 cycles (2 periods of 9) after the first IN_FLAG.
  - DONE pulses on the next cycle and BUSY falls.
- START with FIRST=0, LAST=2:
  - LAYER goes 0→1→2, KERNEL_MODE goes 00→01→10.
  - Three LAYER_DONE pulses, then one DONE.
  - Each layer runs 18, 66 and 128 cycles of IN_FLAG spacing respectively.
- START with FIRST=2, LAST=1, then FIRST=3, LAST=3: CFG_ERR pulses once per request and BUSY stays 0.
- ABORT in layer 1 when PASS_CNT=1, with START asserted in the same cycle: IDLE next cycle, KERNEL_MODE=11, and no DONE or LAYER_DONE.
- RESET_N=0 mid-run during layer 2: all outputs return to their reset values on the next falling edge; a following START runs normally.

Source files
------------

// File: rtl/kernel_pkg.sv
// Shared definitions for the kernel layer sequencer and kernel control:
// mode encodings, sequencer states and per-mode kernel periods.
package kernel_pkg;

  localparam logic [1:0] MODE_K0   = 2'b00;
  localparam logic [1:0] MODE_K1   = 2'b01;
  localparam logic [1:0] MODE_K2   = 2'b10;
  localparam logic [1:0] MODE_PARK = 2'b11;

  localparam int PERIOD_K0 = 9;
  localparam int PERIOD_K1 = 33;
  localparam int PERIOD_K2 = 128;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    NEXT,
    FIN
  } seq_state_t;

  // A run is legal only when it walks forward through existing layers.
  function automatic logic cfg_ok(input logic [1:0] first, input logic [1:0] last);
    return (last <= 2'd2) && (first <= last);
  endfunction

endpackage

// File: rtl/kernel_pass_counter.sv
// Counts kernel passes from the period-start flag: the first flag only opens
// pass 1, each later flag closes a pass; saturates at the layer limit.
module kernel_pass_counter
  import kernel_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             flag,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic armed;
  logic bump;

  assign bump = enable && flag && armed && (count < limit);
  // term fires on the very flag that closes the last pass, not a cycle later.
  assign term = bump && ((count + CNT_W'(1)) == limit);

  always_ff @(negedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
      armed <= 1'b0;
    end else if (enable && flag) begin
      if (!armed) begin
        armed <= 1'b1;
      end else if (bump) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/kernel_layer_sequencer.sv
// Steps kernel control through layers FIRST..LAST (modes 00/01/10), runs a
// fixed number of kernel passes per layer and reports layer/run completion.
module kernel_layer_sequencer
  import kernel_pkg::*;
#(
  parameter int PASS_L0 = 4,
  parameter int PASS_L1 = 16,
  parameter int PASS_L2 = 64,
  parameter int CNT_W   = 7
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [1:0]       FIRST_LAYER,
  input  logic [1:0]       LAST_LAYER,
  input  logic             IN_FLAG,
  output logic [1:0]       KERNEL_MODE,
  output logic             KERN_RST,
  output logic [1:0]       LAYER,
  output logic [CNT_W-1:0] PASS_CNT,
  output logic             BUSY,
  output logic             LAYER_DONE,
  output logic             DONE,
  output logic             CFG_ERR
);

  seq_state_t       state, state_nx;
  logic [1:0]       last_layer;
  logic [CNT_W-1:0] limit;
  logic             start_ok;
  logic             start_bad;
  logic             term;

  assign start_ok  = (state == IDLE) && START && !ABORT && cfg_ok(FIRST_LAYER, LAST_LAYER);
  assign start_bad = (state == IDLE) && START && !ABORT && !cfg_ok(FIRST_LAYER, LAST_LAYER);

  always_comb begin
    case (LAYER)
      2'd0:    limit = CNT_W'(PASS_L0);
      2'd1:    limit = CNT_W'(PASS_L1);
      default: limit = CNT_W'(PASS_L2);
    endcase
  end

  kernel_pass_counter #(
    .CNT_W(CNT_W)
  ) u_pass_counter (
    .clk   (CLK),
    .rst_n (RESET_N),
    .clear ((state_nx == ARM) || ABORT),
    .enable(state == RUN),
    .flag  (IN_FLAG),
    .limit (limit),
    .count (PASS_CNT),
    .term  (term)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_ok) state_nx = ARM;
      ARM:     state_nx = RUN;
      RUN:     if (term) state_nx = NEXT;
      NEXT:    state_nx = (LAYER == last_layer) ? FIN : ARM;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort wins over start, pass completion and layer advance alike.
    if (ABORT) state_nx = IDLE;
  end

  always_comb begin
    KERNEL_MODE = MODE_PARK;
    KERN_RST    = 1'b0;
    BUSY        = 1'b1;
    LAYER_DONE  = 1'b0;
    DONE        = 1'b0;
    case (state)
      IDLE: BUSY = 1'b0;
      ARM: begin
        KERNEL_MODE = LAYER;
        KERN_RST    = 1'b1;
      end
      RUN:     KERNEL_MODE = LAYER;
      NEXT:    LAYER_DONE  = 1'b1;
      FIN:     DONE        = 1'b1;
      default: BUSY        = 1'b1;
    endcase
  end

  always_ff @(negedge CLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      LAYER      <= 2'd0;
      last_layer <= 2'd0;
      CFG_ERR    <= 1'b0;
    end else begin
      state   <= state_nx;
      CFG_ERR <= start_bad;
      if (start_ok) begin
        LAYER      <= FIRST_LAYER;
        last_layer <= LAST_LAYER;
      end else if ((state == NEXT) && !ABORT && (LAYER != last_layer)) begin
        LAYER <= LAYER + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_kernel_layer_sequencer.sv
// Scoreboard bench for kernel_layer_sequencer with a behavioural kernel
// control model producing IN_FLAG at the mode's period.
module tb_kernel_layer_sequencer;
  import kernel_pkg::*;

  localparam int CNT_W = 7;
  localparam int K_KRST = 0, K_LDONE = 1, K_DONE = 2, K_CFG = 3;

  logic             clk = 1'b0;
  logic             RESET_N, START, ABORT, IN_FLAG;
  logic [1:0]       FIRST_LAYER, LAST_LAYER;
  logic [1:0]       KERNEL_MODE, LAYER;
  logic             KERN_RST, BUSY, LAYER_DONE, DONE, CFG_ERR;
  logic [CNT_W-1:0] PASS_CNT;

  typedef struct {
    int kind;
    int layer;
    int mode;
    int pcnt;
    int gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   pl_tab[3]  = '{2, 2, 1};
  int   gap_tab[3] = '{18, 66, 128};

  always #5 clk = ~clk;

  kernel_layer_sequencer #(
    .PASS_L0(2),
    .PASS_L1(2),
    .PASS_L2(1),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK        (clk),
    .RESET_N    (RESET_N),
    .START      (START),
    .ABORT      (ABORT),
    .FIRST_LAYER(FIRST_LAYER),
    .LAST_LAYER (LAST_LAYER),
    .IN_FLAG    (IN_FLAG),
    .KERNEL_MODE(KERNEL_MODE),
    .KERN_RST   (KERN_RST),
    .LAYER      (LAYER),
    .PASS_CNT   (PASS_CNT),
    .BUSY       (BUSY),
    .LAYER_DONE (LAYER_DONE),
    .DONE       (DONE),
    .CFG_ERR    (CFG_ERR)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int layer, input int mode, input int pcnt, input int gap);
    exp_t e;
    e.kind = kind; e.layer = layer; e.mode = mode; e.pcnt = pcnt; e.gap = gap;
    sb.push_back(e);
  endtask

  function automatic int period(input logic [1:0] mode);
    case (mode)
      MODE_K0: return PERIOD_K0;
      MODE_K1: return PERIOD_K1;
      default: return PERIOD_K2;
    endcase
  endfunction

  // Kernel control model: parked in mode 11, restarted by KERN_RST,
  // otherwise a one-cycle flag at the start of every period.
  initial begin : kc_model
    int kc;
    kc = 0;
    IN_FLAG = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!RESET_N || KERN_RST || KERNEL_MODE == MODE_PARK) begin
        kc = 0;
        IN_FLAG = 1'b0;
      end else begin
        IN_FLAG = (kc == 0);
        kc = (kc == period(KERNEL_MODE) - 1) ? 0 : kc + 1;
      end
    end
  end

  initial begin : monitor
    int   cyc, first_flag_cyc, last_ld_cyc, prev_pcnt, kind;
    logic wait_first;
    exp_t e;
    cyc = 0; first_flag_cyc = 0; last_ld_cyc = 0; prev_pcnt = 0; wait_first = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (IN_FLAG === 1'b1 && wait_first) begin
        first_flag_cyc = cyc;
        wait_first = 1'b0;
      end
      if (BUSY === 1'b1 && int'(PASS_CNT) != prev_pcnt && PASS_CNT != 0)
        chk("pass_step", int'(PASS_CNT), prev_pcnt + 1);
      prev_pcnt = int'(PASS_CNT);
      if (KERN_RST === 1'b1 || LAYER_DONE === 1'b1 || DONE === 1'b1 || CFG_ERR === 1'b1) begin
        kind = KERN_RST ? K_KRST : LAYER_DONE ? K_LDONE : DONE ? K_DONE : K_CFG;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
        end else begin
          e = sb.pop_front();
          chk("evt_kind", kind, e.kind);
          chk("evt_mode", int'(KERNEL_MODE), e.mode);
          if (e.kind == K_CFG) begin
            chk("cfg_busy", int'(BUSY), 0);
          end else begin
            chk("evt_layer", int'(LAYER), e.layer);
            chk("evt_pass_cnt", int'(PASS_CNT), e.pcnt);
          end
          if (e.kind == K_LDONE) chk("layer_gap", cyc - first_flag_cyc, e.gap);
          if (e.kind == K_DONE)  chk("done_gap", cyc - last_ld_cyc, e.gap);
        end
        if (KERN_RST) wait_first = 1'b1;
        if (LAYER_DONE) last_ld_cyc = cyc;
      end
    end
  end

  task automatic pulse_start(input int f, input int l);
    @(posedge clk);
    #1;
    START = 1'b1;
    FIRST_LAYER = 2'(f);
    LAST_LAYER  = 2'(l);
    @(posedge clk);
    #1;
    START = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(posedge clk);
      if (DONE === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no DONE expected DONE within %0d cycles", budget);
    end
  endtask

  task automatic run(input int f, input int l);
    for (int k = f; k <= l; k++) begin
      push(K_KRST, k, k, 0, 0);
      push(K_LDONE, k, 3, pl_tab[k], gap_tab[k]);
    end
    push(K_DONE, l, 3, pl_tab[l], 1);
    pulse_start(f, l);
    wait_done(3000);
    @(posedge clk);
    chk("busy_after_done", int'(BUSY), 0);
    chk("mode_after_done", int'(KERNEL_MODE), 3);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mode"}, int'(KERNEL_MODE), 3);
    chk({tag, "_krst"}, int'(KERN_RST), 0);
    chk({tag, "_layer"}, int'(LAYER), 0);
    chk({tag, "_pass_cnt"}, int'(PASS_CNT), 0);
    chk({tag, "_busy"}, int'(BUSY), 0);
    chk({tag, "_layer_done"}, int'(LAYER_DONE), 0);
    chk({tag, "_done"}, int'(DONE), 0);
    chk({tag, "_cfg_err"}, int'(CFG_ERR), 0);
  endtask

  initial begin : stimulus
    bit hit;
    RESET_N = 1'b0; START = 1'b0; ABORT = 1'b0;
    FIRST_LAYER = 2'd0; LAST_LAYER = 2'd0;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    #1;
    RESET_N = 1'b1;
    repeat (50) begin
      @(posedge clk);
      chk("idle_mode", int'(KERNEL_MODE), 3);
      chk("idle_busy", int'(BUSY), 0);
    end

    run(0, 0);
    run(0, 2);

    push(K_CFG, 0, 3, 0, 0);
    pulse_start(2, 1);
    repeat (3) begin
      @(posedge clk);
      chk("cfg_a_busy", int'(BUSY), 0);
    end
    push(K_CFG, 0, 3, 0, 0);
    pulse_start(3, 3);
    repeat (3) begin
      @(posedge clk);
      chk("cfg_b_busy", int'(BUSY), 0);
    end

    push(K_KRST, 0, 0, 0, 0);
    push(K_LDONE, 0, 3, 2, 18);
    push(K_KRST, 1, 1, 0, 0);
    pulse_start(0, 2);
    hit = 1'b0;
    for (int n = 0; n < 2000 && !hit; n++) begin
      @(posedge clk);
      if (LAYER == 2'd1 && PASS_CNT == 1 && BUSY === 1'b1) hit = 1'b1;
    end
    chk("abort_reached_l1_p1", int'(hit), 1);
    #1;
    ABORT = 1'b1; START = 1'b1; FIRST_LAYER = 2'd0; LAST_LAYER = 2'd0;
    @(posedge clk);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_mode", int'(KERNEL_MODE), 3);
    chk("abort_pass_cnt", int'(PASS_CNT), 0);
    chk("abort_layer_done", int'(LAYER_DONE), 0);
    chk("abort_done", int'(DONE), 0);
    #1;
    ABORT = 1'b0; START = 1'b0;
    repeat (200) @(posedge clk);
    chk("abort_busy_later", int'(BUSY), 0);
    chk("abort_pending", sb.size(), 0);

    push(K_KRST, 2, 2, 0, 0);
    pulse_start(2, 2);
    repeat (40) @(posedge clk);
    chk("midrun_busy", int'(BUSY), 1);
    chk("midrun_layer", int'(LAYER), 2);
    #1;
    RESET_N = 1'b0;
    @(posedge clk);
    check_reset_outputs("midrun_reset");
    #1;
    RESET_N = 1'b1;
    run(1, 1);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
